axi_mem_master: RTL and testbench
=================================

AXI_MEM_MASTER -- requirements
Module: axi_mem_master

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 Parameter CMD_DEPTH, default 4, SHALL set the number of client command queue entries (power of two, at least 2).
REQ-003 Parameter TIMEOUT_CYCLES, default 64, SHALL set the read watchdog limit in clk cycles (used only with the Configuration feature).
REQ-004 The ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- cmd_valid  in  1  client command offered.
- cmd_ready  out  1  queue can accept.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  read response held.
- rsp_ready  in  1  client accepts response.
- rsp_data  out  32  read data.
- rsp_err  out  1  response produced by timeout.
- write_valid  out  1  write request.
- write_ready  in  1  responder accepts write.
- write_addr  out  32  write address.
- write_data  out  32  write data.
- read_valid  out  1  read request.
- read_ready  in  1  responder accepts read.
- read_addr  out  32  read address.
- read_data  in  32  responder read data.
- fifo_empty  in  1  responder queue empty.
- fifo_full  in  1  responder queue full (status only).
- wr_count  out  32  write handshakes issued.
- rd_count  out  32  read handshakes issued.

Function
REQ-005 Client push SHALL occur on cmd_valid && cmd_ready; cmd_ready SHALL equal !queue_full; a push and a pop in the same cycle SHALL be allowed and SHALL leave the occupancy unchanged.
REQ-006 The FSM SHALL have the states IDLE, WR, DRAIN, RD, WAIT_RD and RESP, and SHALL process commands strictly in order.
REQ-007 IDLE: if the queue is non-empty, the FSM SHALL go to WR for a head write or to DRAIN for a head read.
REQ-008 WR SHALL assert write_valid with write_addr/write_data taken from the head entry, held stable until write_ready; on the handshake it SHALL pop the entry, increment wr_count, and go to WR again in the next cycle if the new head is a write (write_valid stays high, no bubble), otherwise go to IDLE.
REQ-009 DRAIN SHALL wait until fifo_empty is sampled 1, then go to RD.
REQ-010 RD SHALL assert read_valid with read_addr, held until read_ready; on the handshake it SHALL pop the entry, increment rd_count and go to WAIT_RD.
REQ-011 WAIT_RD SHALL capture read_data into rsp_data on the first edge at which fifo_empty is sampled 1, then go to RESP; against the team memory responder this edge SHALL be the 4th edge after the read handshake edge.
REQ-012 RESP SHALL hold rsp_valid=1 with rsp_data stable until rsp_ready, then go to IDLE; no new request SHALL be issued while in RESP.
REQ-013 write_valid and read_valid SHALL never both be 1.
REQ-014 wr_count and rd_count SHALL wrap modulo 2^32.
REQ-015 write_addr/write_data/read_addr SHALL be 0 whenever the corresponding valid is 0.

Reset
REQ-016 Asserting reset SHALL, at any time including mid-handshake, force every output to 0 except cmd_ready=1, empty the queue, drop any pending response, and put the FSM in IDLE.

Configuration
REQ-017 With AXI_MEM_MASTER_TIMEOUT_EN defined, a WAIT_RD lasting TIMEOUT_CYCLES cycles SHALL set rsp_data=32'hDEADBEEF and rsp_err=1, then go to RESP.
REQ-018 Without AXI_MEM_MASTER_TIMEOUT_EN, WAIT_RD SHALL wait indefinitely, rsp_err SHALL be tied to 0, and no watchdog counter SHALL exist.

Structure
REQ-019 mem_pkg SHALL hold the command entry struct (write, addr, wdata), the master state enum, and the DEADBEEF constant.
REQ-020 The command queue SHALL be a sub-module named axi_cmd_fifo (parameterised width and depth, with full/empty flags).

Verification
REQ-021 Write 0x100=0xA5A50001, then read 0x100 -> rsp_data=0xA5A50001, with rsp_valid high 4 edges after the read handshake.
REQ-022 Read 0x0 after reset -> rsp_data=0x00000400, rd_count=1.
REQ-023 4 queued writes with write_ready=1 -> write_valid high for 4 consecutive cycles, wr_count=4.
REQ-024 write_ready=0 for 10 cycles while pushing 6 commands -> write_valid/write_addr/write_data stable, cmd_ready=0 after 4 buffered.
REQ-025 rsp_ready=0 for 5 cycles with a second read queued -> rsp_data held, read_valid stays 0 until RESP exits.
REQ-026 With AXI_MEM_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=16 and fifo_empty forced to 0 -> rsp_data=0xDEADBEEF and rsp_err=1 after 16 cycles.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory master: command entry, FSM states,
// and the data word returned when a read is abandoned by the watchdog.
package mem_pkg;

  typedef struct packed {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  localparam int CMD_W = $bits(cmd_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_DRAIN,
    ST_RD,
    ST_WAIT_RD,
    ST_RESP
  } mst_state_t;

  localparam logic [31:0] TMO_DATA = 32'hDEADBEEF;

endpackage

// File: rtl/axi_cmd_fifo.sv
// Client command queue: power-of-two circular buffer with full/empty.
// Ports: i_push/i_data in, i_pop; o_head (entry at head), o_next
// (entry behind head, valid when o_next_vld), o_full, o_empty.
module axi_cmd_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic [WIDTH-1:0] o_next,
  output logic             o_next_vld,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd;
  logic [AW-1:0]    r_wr;
  logic [AW:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push     = i_push && !o_full;
  assign w_pop      = i_pop && !o_empty;
  assign o_full     = (r_cnt == (AW+1)'(DEPTH));
  assign o_empty    = (r_cnt == '0);
  assign o_next_vld = (r_cnt > (AW+1)'(1));
  assign o_head     = r_mem[r_rd];
  assign o_next     = r_mem[r_rd + AW'(1)];

  // Storage carries no reset; only the pointers define contents.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      if (w_push && !w_pop)
        r_cnt <= r_cnt + (AW+1)'(1);
      else if (w_pop && !w_push)
        r_cnt <= r_cnt - (AW+1)'(1);
    end
  end

endmodule

// File: rtl/axi_mem_master.sv
// In-order memory master: queues client commands, issues writes
// back-to-back, drains the responder before each read, returns data.
// Ports: cmd_* client queue, rsp_* read response, write_*/read_*
// responder requests, fifo_empty/fifo_full responder status,
// wr_count/rd_count handshake counters.
// Option: AXI_MEM_MASTER_TIMEOUT_EN adds a read watchdog
// (TIMEOUT_CYCLES) returning TMO_DATA with rsp_err=1.
import mem_pkg::*;

module axi_mem_master #(
  parameter int CMD_DEPTH      = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_err,
  output logic        write_valid,
  input  logic        write_ready,
  output logic [31:0] write_addr,
  output logic [31:0] write_data,
  output logic        read_valid,
  input  logic        read_ready,
  output logic [31:0] read_addr,
  input  logic [31:0] read_data,
  input  logic        fifo_empty,
  input  logic        fifo_full,
  output logic [31:0] wr_count,
  output logic [31:0] rd_count
);

  mst_state_t  r_state;
  mst_state_t  w_nxt;
  cmd_t        w_push_cmd;
  cmd_t        w_head;
  cmd_t        w_nxt_cmd;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  logic        w_nxt_vld;
  logic        w_nxt_wr;
  logic        w_tmo;
  logic        w_unused;
  logic [31:0] r_wr_cnt;
  logic [31:0] r_rd_cnt;
  logic [31:0] r_rsp_data;

  assign cmd_ready  = !w_full;
  assign w_push     = cmd_valid && !w_full;
  assign w_push_cmd = '{write: cmd_write,
                        addr:  cmd_addr,
                        wdata: cmd_wdata};

  axi_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (CMD_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_push     (w_push),
    .i_data     (w_push_cmd),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_next     (w_nxt_cmd),
    .o_next_vld (w_nxt_vld),
    .o_full     (w_full),
    .o_empty    (w_empty)
  );

  // Head after a pop: the second entry, or the entry being pushed
  // this cycle when the popped one was the last.
  assign w_nxt_wr = w_nxt_vld ? w_nxt_cmd.write
                              : (w_push && cmd_write);

  assign w_unused = ^{fifo_full, w_nxt_cmd.addr,
                      w_nxt_cmd.wdata,
                      (TIMEOUT_CYCLES > 0)};

  always_comb begin
    w_nxt       = r_state;
    w_pop       = 1'b0;
    write_valid = 1'b0;
    write_addr  = '0;
    write_data  = '0;
    read_valid  = 1'b0;
    read_addr   = '0;
    unique case (r_state)
      ST_IDLE: begin
        if (!w_empty)
          w_nxt = w_head.write ? ST_WR : ST_DRAIN;
      end
      ST_WR: begin
        write_valid = 1'b1;
        write_addr  = w_head.addr;
        write_data  = w_head.wdata;
        if (write_ready) begin
          w_pop = 1'b1;
          w_nxt = w_nxt_wr ? ST_WR : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty) w_nxt = ST_RD;
      end
      ST_RD: begin
        read_valid = 1'b1;
        read_addr  = w_head.addr;
        if (read_ready) begin
          w_pop = 1'b1;
          w_nxt = ST_WAIT_RD;
        end
      end
      ST_WAIT_RD: begin
        if (fifo_empty || w_tmo) w_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) w_nxt = ST_IDLE;
      end
      default: w_nxt = ST_IDLE;
    endcase
  end

`ifdef AXI_MEM_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] r_tmo;
  logic          r_rsp_err;
  logic          w_wait;

  assign w_wait = (r_state == ST_WAIT_RD) && !fifo_empty;
  assign w_tmo  = w_wait
               && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign rsp_err = r_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tmo     <= '0;
      r_rsp_err <= 1'b0;
    end else begin
      r_tmo <= w_wait ? r_tmo + TW'(1) : '0;
      if (r_state == ST_WAIT_RD && fifo_empty)
        r_rsp_err <= 1'b0;
      else if (w_tmo)
        r_rsp_err <= 1'b1;
    end
  end
`else
  assign w_tmo   = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_rd_cnt   <= '0;
      r_rsp_data <= '0;
    end else begin
      r_state <= w_nxt;
      if (r_state == ST_WR && write_ready)
        r_wr_cnt <= r_wr_cnt + 32'd1;
      if (r_state == ST_RD && read_ready)
        r_rd_cnt <= r_rd_cnt + 32'd1;
      if (r_state == ST_WAIT_RD && fifo_empty)
        r_rsp_data <= read_data;
      else if (w_tmo)
        r_rsp_data <= TMO_DATA;
    end
  end

  assign rsp_valid = (r_state == ST_RESP);
  assign rsp_data  = r_rsp_data;
  assign wr_count  = r_wr_cnt;
  assign rd_count  = r_rd_cnt;

endmodule

// File: tb/tb_axi_mem_master.sv
// Directed bench for axi_mem_master with a small memory responder.
// Responder: writes busy 2 cycles, reads busy 3 cycles after handshake.
module tb_axi_mem_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        write_valid;
  logic        write_ready = 1'b1;
  logic [31:0] write_addr;
  logic [31:0] write_data;
  logic        read_valid;
  logic        read_ready = 1'b1;
  logic [31:0] read_addr;
  logic [31:0] read_data;
  logic        fifo_empty;
  logic        fifo_full = 1'b0;
  logic [31:0] wr_count;
  logic [31:0] rd_count;

  axi_mem_master #(
    .CMD_DEPTH      (4),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_write   (cmd_write),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .rsp_err     (rsp_err),
    .write_valid (write_valid),
    .write_ready (write_ready),
    .write_addr  (write_addr),
    .write_data  (write_data),
    .read_valid  (read_valid),
    .read_ready  (read_ready),
    .read_addr   (read_addr),
    .read_data   (read_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .wr_count    (wr_count),
    .rd_count    (rd_count)
  );

  always #5 clk = ~clk;

  // responder
  logic [31:0]  mem [256];
  logic [255:0] mem_v;
  logic [2:0]   rcnt;
  logic [2:0]   wcnt;
  logic         force_busy = 1'b0;

  assign fifo_empty = (rcnt == 3'd0) && (wcnt == 3'd0)
                   && !force_busy;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rcnt      <= '0;
      wcnt      <= '0;
      mem_v     <= '0;
      read_data <= '0;
    end else begin
      if (rcnt != 0) rcnt <= rcnt - 3'd1;
      if (wcnt != 0) wcnt <= wcnt - 3'd1;
      if (write_valid && write_ready) begin
        mem[write_addr[9:2]]   <= write_data;
        mem_v[write_addr[9:2]] <= 1'b1;
        wcnt <= 3'd2;
      end
      if (read_valid && read_ready) begin
        read_data <= mem_v[read_addr[9:2]]
                   ? mem[read_addr[9:2]]
                   : 32'h400 + read_addr;
        rcnt <= 3'd3;
      end
    end
  end

  // edge counter and handshake monitors
  int          ecnt = 0;
  int          hs_edge = 0;
  logic        both_seen = 1'b0;
  logic        zero_bad = 1'b0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clk) begin
    ecnt <= ecnt + 1;
    if (rst_n) begin
      if (read_valid && read_ready) hs_edge <= ecnt + 1;
      if (write_valid && write_ready) begin
        last_wa <= write_addr;
        last_wd <= write_data;
      end
      if (write_valid && read_valid) both_seen <= 1'b1;
      if (!write_valid && (write_addr != 0 || write_data != 0))
        zero_bad <= 1'b1;
      if (!read_valid && read_addr != 0) zero_bad <= 1'b1;
    end
  end

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic push(input logic w,
                      input logic [31:0] a,
                      input logic [31:0] d);
    int t = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("push_timeout", 32'd1, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
  endtask

  task automatic wait_rsp(output int lat);
    int t = 0;
    while (!rsp_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("rsp_timeout", 32'd0, 32'd1);
    lat = ecnt - hs_edge;
  endtask

  task automatic wait_rd_valid();
    int t = 0;
    while (!read_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("rdv_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int k;
    int c;
    logic stall_bad;
    logic rv_seen;
    logic hold_bad;

    do_reset();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_write_valid", write_valid, 0);
    chk("rst_read_valid", read_valid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_rd_count", rd_count, 0);

    // read of untouched word 0
    push(1'b0, 32'h0, 32'h0);
    wait_rsp(lat);
    chk("rd0_data", rsp_data, 32'h400);
    chk("rd0_rd_count", rd_count, 1);
    chk("rd0_err", rsp_err, 0);
    @(negedge clk);

    // write then read back, 4-edge response latency
    push(1'b1, 32'h100, 32'hA5A50001);
    push(1'b0, 32'h100, 32'h0);
    wait_rsp(lat);
    chk("wr_rd_data", rsp_data, 32'hA5A50001);
    chk("wr_rd_lat", lat, 4);
    chk("wr_rd_wr_count", wr_count, 1);
    chk("wr_rd_rd_count", rd_count, 2);
    @(negedge clk);

    // four queued writes leave back-to-back
    do_reset();
    write_ready = 1'b0;
    for (int i = 0; i < 4; i++)
      push(1'b1, 32'h200 + 4*i, 32'hB000_0000 + i);
    chk("b2b_full", cmd_ready, 0);
    write_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_valid", write_valid, 1);
      chk("b2b_addr", write_addr, 32'h200 + 4*i);
      @(negedge clk);
    end
    chk("b2b_end", write_valid, 0);
    chk("b2b_wr_count", wr_count, 4);

    // stalled writer while six commands are offered
    do_reset();
    write_ready = 1'b0;
    stall_bad = 1'b0;
    k = 0;
    c = 0;
    while (c < 60 && !(k == 6 && wr_count == 6)) begin
      if (c >= 2 && c <= 10) begin
        if (write_valid !== 1'b1
            || write_addr !== 32'h300
            || write_data !== 32'hC000_0000)
          stall_bad = 1'b1;
      end
      if (c == 10) begin
        chk("stall_cmd_ready", cmd_ready, 0);
        chk("stall_buffered", k, 4);
      end
      write_ready = (c >= 10);
      if (k < 6) begin
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h300 + 4*k;
        cmd_wdata = 32'hC000_0000 + k;
        if (cmd_ready) k++;
      end else begin
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
      end
      @(negedge clk);
      c++;
    end
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    chk("stall_stable", stall_bad, 0);
    chk("stall_wr_count", wr_count, 6);
    chk("stall_last_addr", last_wa, 32'h314);
    chk("stall_last_data", last_wd, 32'hC000_0005);

    // response back-pressure with a second read queued
    do_reset();
    rsp_ready = 1'b0;
    push(1'b0, 32'h40, 32'h0);
    push(1'b0, 32'h44, 32'h0);
    wait_rsp(lat);
    chk("bp_data", rsp_data, 32'h440);
    rv_seen = 1'b0;
    hold_bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (read_valid) rv_seen = 1'b1;
      if (rsp_data !== 32'h440 || !rsp_valid)
        hold_bad = 1'b1;
    end
    chk("bp_hold", hold_bad, 0);
    chk("bp_no_read", rv_seen, 0);
    rsp_ready = 1'b1;
    @(negedge clk);
    wait_rsp(lat);
    chk("bp_data2", rsp_data, 32'h444);
    chk("bp_rd_count", rd_count, 2);
    @(negedge clk);

    // reset in the middle of a stalled write
    write_ready = 1'b0;
    push(1'b1, 32'h500, 32'h1234_5678);
    @(negedge clk);
    chk("mid_pre_valid", write_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_write_valid", write_valid, 0);
    chk("mid_write_addr", write_addr, 0);
    chk("mid_write_data", write_data, 0);
    chk("mid_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    write_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("mid_dropped_wv", write_valid, 0);
    chk("mid_dropped_cnt", wr_count, 0);

`ifdef AXI_MEM_MASTER_TIMEOUT_EN
    // watchdog fires when the responder never drains
    do_reset();
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 32'h80;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    wait_rd_valid();
    force_busy = 1'b1;
    @(negedge clk);
    wait_rsp(lat);
    chk("tmo_data", rsp_data, 32'hDEADBEEF);
    chk("tmo_err", rsp_err, 1);
    chk("tmo_lat", lat, 16);
    force_busy = 1'b0;
    @(negedge clk);
`endif

    chk("valid_exclusive", both_seen, 0);
    chk("addr_zero_idle", zero_bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

endmodule
